// File: rtl/uart_rx_fifo.sv
// UART receive engine (8N1, LSB first) feeding a show-ahead receive FIFO with sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a PARITY state and a sticky parity_err output.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic                        rx_in,
   input  logic                        rd_en,
   output logic [7:0]                  rd_data,
   output logic                        rd_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overrun,
   output logic                        frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                        parity_err,
`endif
   input  logic                        err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] HALF_LAST  = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
      , PARITY = 3'd4
`endif
   } state_t;

`ifdef UART_RX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] data);
      even_parity = ^data;
   endfunction
`endif

   logic [1:0]    sync_r;
   logic          prev_r;
   logic          line_s;
   logic          fall_s;
   state_t        state_r;
   logic [BW-1:0] bcnt_r;
   logic [2:0]    bidx_r;
   logic [7:0]    shift_r;
   logic          push_r;
   logic [7:0]    push_data_r;
   logic          frame_err_r;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_r;
   logic          parity_err_r;
`endif

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic [7:0]    rd_data_r;
   logic          rd_valid_r;
   logic          overrun_r;

   logic          pop_s;
   logic          push_ok_s;
   logic [AW-1:0] rptr_nxt_s;
   logic [AW:0]   count_nxt_s;
   logic [7:0]    head_nxt_s;

   assign line_s = sync_r[1];
   assign fall_s = prev_r & ~line_s;

   // Line synchroniser, edge detector and frame state machine.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         sync_r      <= 2'b11;
         prev_r      <= 1'b1;
         state_r     <= IDLE;
         bcnt_r      <= '0;
         bidx_r      <= 3'd0;
         shift_r     <= 8'h00;
         push_r      <= 1'b0;
         push_data_r <= 8'h00;
         frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_r    <= 1'b0;
         parity_err_r <= 1'b0;
`endif
      end else begin
         sync_r <= {sync_r[0], rx_in};
         prev_r <= sync_r[1];
         push_r <= 1'b0;
         // A clear in the same cycle as a set is overridden by the later set below.
         if (err_clr) begin
            frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
         end
         case (state_r)
            IDLE: begin
               bcnt_r <= '0;
               if (fall_s) begin
                  state_r <= START;
               end
            end
            START: begin
               if (bcnt_r == HALF_LAST) begin
                  bcnt_r  <= '0;
                  bidx_r  <= 3'd0;
                  state_r <= line_s ? IDLE : DATA;
               end else begin
                  bcnt_r <= bcnt_r + 1'b1;
               end
            end
            DATA: begin
               if (bcnt_r == BIT_LAST) begin
                  shift_r[bidx_r] <= line_s;
                  bcnt_r          <= '0;
                  bidx_r          <= bidx_r + 3'd1;
                  if (bidx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_r <= PARITY;
`else
                     state_r <= STOP;
`endif
                  end
               end else begin
                  bcnt_r <= bcnt_r + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bcnt_r == BIT_LAST) begin
                  par_bad_r <= (even_parity(shift_r) != line_s);
                  bcnt_r    <= '0;
                  state_r   <= STOP;
               end else begin
                  bcnt_r <= bcnt_r + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bcnt_r == BIT_LAST) begin
                  bcnt_r  <= '0;
                  state_r <= IDLE;
                  if (!line_s) begin
                     frame_err_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (par_bad_r) begin
                     parity_err_r <= 1'b1;
`endif
                  end else begin
                     push_r      <= 1'b1;
                     push_data_r <= shift_r;
                  end
               end else begin
                  bcnt_r <= bcnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               bcnt_r  <= '0;
            end
         endcase
      end
   end

   // Next FIFO state; the head bypasses storage when it is written this cycle.
   always_comb begin
      pop_s       = rd_en && (count_r != '0);
      push_ok_s   = push_r && ((count_r != FULL_COUNT) || pop_s);
      rptr_nxt_s  = rptr_r;
      count_nxt_s = count_r;
      head_nxt_s  = 8'h00;
      if (pop_s) begin
         rptr_nxt_s = rptr_r + 1'b1;
      end else begin
         rptr_nxt_s = rptr_r;
      end
      if (push_ok_s && !pop_s) begin
         count_nxt_s = count_r + 1'b1;
      end else if (pop_s && !push_ok_s) begin
         count_nxt_s = count_r - 1'b1;
      end else begin
         count_nxt_s = count_r;
      end
      if (count_nxt_s == '0) begin
         head_nxt_s = 8'h00;
      end else if (push_ok_s && (wptr_r == rptr_nxt_s)) begin
         head_nxt_s = push_data_r;
      end else begin
         head_nxt_s = mem_r[rptr_nxt_s];
      end
   end

   // FIFO storage, left unreset.
   always_ff @(posedge ACLK) begin
      if (push_ok_s) begin
         mem_r[wptr_r] <= push_data_r;
      end
   end

   // FIFO pointers, occupancy, registered head and overrun flag.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wptr_r     <= '0;
         rptr_r     <= '0;
         count_r    <= '0;
         rd_data_r  <= 8'h00;
         rd_valid_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wptr_r <= wptr_r + 1'b1;
         end
         rptr_r     <= rptr_nxt_s;
         count_r    <= count_nxt_s;
         rd_data_r  <= head_nxt_s;
         rd_valid_r <= (count_nxt_s != '0);
         if (err_clr) begin
            overrun_r <= 1'b0;
         end
         if (push_r && !push_ok_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign rd_data    = rd_data_r;
   assign rd_valid   = rd_valid_r;
   assign fifo_count = count_r;
   assign overrun    = overrun_r;
   assign frame_err  = frame_err_r;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, scoreboard of expected bytes popped and compared.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int LAT_NOM = 2 + CPB / 2 + 10 * CPB + 1;
`else
   localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB + 1;
`endif

   logic       tb_ACLK = 1'b0;
   logic       ARESET;
   logic       rx_in;
   logic       rd_en;
   logic       err_clr;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [2:0] fifo_count;
   logic       overrun;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       par_flip = 1'b0;
`endif

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   int         lat      = 0;
   logic       seen     = 1'b0;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .ACLK       (tb_ACLK),
      .ARESET     (ARESET),
      .rx_in      (rx_in),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .fifo_count (fifo_count),
      .overrun    (overrun),
      .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .err_clr    (err_clr)
   );

   always #5 tb_ACLK = ~tb_ACLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no end of test by 1 ms, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge tb_ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         tick(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rx_in = (^b) ^ par_flip;
      tick(CPB);
`endif
      rx_in = stop_bit;
      tick(CPB);
      rx_in = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      check({tag, "_count"}, fifo_count, exp_q.size());
      check({tag, "_valid"}, rd_valid, 1'b1);
      e = exp_q.pop_front();
      check({tag, "_data"}, rd_data, e);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   initial begin
      ARESET = 1'b1; rx_in = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      tick(4);
      check("rst_valid", rd_valid, 1'b0);
      check("rst_count", fifo_count, 3'd0);
      check("rst_data", rd_data, 8'h00);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame", frame_err, 1'b0);
      ARESET = 1'b0;
      tick(2);

      // Pop while empty is ignored.
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      check("empty_pop_count", fifo_count, 3'd0);
      check("empty_pop_valid", rd_valid, 1'b0);

      // Single byte latency from start edge.
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int n = 1; n <= 300 && !seen; n++) begin
               tick(1);
               if (rd_valid === 1'b1) begin
                  seen = 1'b1;
                  lat  = n;
               end
            end
         end
      join
      exp_q.push_back(8'hA5);
      check("lat_seen", seen, 1'b1);
      check($sformatf("latency_%0d_cycles_in_window", lat),
            (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1), 1'b1);
      pop_check("a5");
      check("a5_after_valid", rd_valid, 1'b0);
      check("a5_after_count", fifo_count, 3'd0);

      // Back-to-back frames with no idle time.
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
      exp_q.push_back(8'h55); exp_q.push_back(8'h3C);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      send_frame(8'h3C, 1'b1);
      tick(4);
      check("b2b_overrun", overrun, 1'b0);
      check("b2b_frame", frame_err, 1'b0);
      for (int i = 0; i < 4; i++) pop_check($sformatf("b2b%0d", i));
      check("b2b_end_count", fifo_count, 3'd0);

      // Overrun: fifth byte dropped.
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      send_frame(8'h99, 1'b1);
      tick(4);
      check("ovr_flag", overrun, 1'b1);
      check("ovr_count", fifo_count, 3'd4);
      check("ovr_head", rd_data, exp_q[0]);
      check("ovr_valid", rd_valid, 1'b1);
      check("ovr_frame", frame_err, 1'b0);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      check("ovr_clr", overrun, 1'b0);

      // Full FIFO with a pop on the push cycle.
      fork
         send_frame(8'h66, 1'b1);
         begin
            tick(lat - 1);
            check("full_pop_data", rd_data, exp_q.pop_front());
            rd_en = 1'b1; tick(1); rd_en = 1'b0;
         end
      join
      exp_q.push_back(8'h66);
      tick(2);
      check("full_pop_overrun", overrun, 1'b0);
      check("full_pop_count", fifo_count, 3'd4);
      for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
      check("drain_count", fifo_count, 3'd0);

      // Stop bit low, then a short glitch on the idle line.
      send_frame(8'h81, 1'b0);
      tick(2);
      check("ferr_flag", frame_err, 1'b1);
      check("ferr_count", fifo_count, 3'd0);
`ifdef UART_RX_PARITY_EN
      check("ferr_no_parity", parity_err, 1'b0);
`endif
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      check("ferr_clr", frame_err, 1'b0);
      rx_in = 1'b0; tick(4); rx_in = 1'b1;
      tick(40);
      check("glitch_count", fifo_count, 3'd0);
      check("glitch_valid", rd_valid, 1'b0);
      check("glitch_frame", frame_err, 1'b0);
      check("glitch_overrun", overrun, 1'b0);

      // Reset in the middle of a frame with two bytes buffered.
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      tick(2);
      check("pre_rst_count", fifo_count, 3'd2);
      fork
         send_frame(8'h7E, 1'b1);
         begin
            tick(136);
            ARESET = 1'b1; tick(1); ARESET = 1'b0;
            check("mid_rst_valid", rd_valid, 1'b0);
            check("mid_rst_count", fifo_count, 3'd0);
            check("mid_rst_data", rd_data, 8'h00);
            check("mid_rst_overrun", overrun, 1'b0);
            check("mid_rst_frame", frame_err, 1'b0);
         end
      join
      exp_q.delete();
      tick(200);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1);
      tick(2);
      check("post_rst_frame", frame_err, 1'b0);
      pop_check("post_rst");
      check("post_rst_empty", fifo_count, 3'd0);

`ifdef UART_RX_PARITY_EN
      check("par_pre", parity_err, 1'b0);
      par_flip = 1'b1;
      send_frame(8'h12, 1'b1);
      par_flip = 1'b0;
      tick(2);
      check("par_flag", parity_err, 1'b1);
      check("par_count", fifo_count, 3'd0);
      check("par_frame", frame_err, 1'b0);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      check("par_clr", parity_err, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
